// File: rtl/upd7800_clkgen.sv
// Phase-strobe generator for the uPD7800 core: CP1/CP2 edge strobes and levels,
// a stretched active-low core reset, and a machine-cycle-aligned HOLD freeze.
module upd7800_clkgen #(
  parameter int CLK_DIV      = 1,
  parameter int RESET_CYCLES = 4
) (
  input  logic CLK,
  input  logic RES,
  input  logic HOLD,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic CP1,
  output logic CP2,
  output logic RESETB,
  output logic HOLD_ACK
);

  localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [7:0]        RC_MAX   = 8'(RESET_CYCLES);
  localparam logic [7:0]        RC_LAST  = 8'(RESET_CYCLES - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } hold_state_t;

  hold_state_t      hold_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       phase_q;
  logic [7:0]       rst_cnt_q;
  logic [3:0]       strobe_q;   // bit index equals the phase that issued it
  logic             cp1_q;
  logic             cp2_q;
  logic             resetb_q;
  logic             step_d;

  assign step_d = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RES) begin
      hold_state_q <= RUN;
      cnt_q        <= '0;
      phase_q      <= 2'd0;
      rst_cnt_q    <= 8'd0;
      strobe_q     <= 4'b0000;
      cp1_q        <= 1'b0;
      cp2_q        <= 1'b0;
      resetb_q     <= 1'b0;
    end else begin
      case (hold_state_q)
        HELD: begin
          strobe_q <= 4'b0000;
          cp1_q    <= 1'b0;
          cp2_q    <= 1'b0;
          if (!HOLD) begin
            hold_state_q <= RUN;
            cnt_q        <= '0;
          end
        end
        RUN: begin
          if (!step_d) begin
            cnt_q    <= cnt_q + 1'b1;
            strobe_q <= 4'b0000;
          end else begin
            cnt_q <= '0;
            // Freeze only on a cycle boundary so a machine cycle is never split.
            if (phase_q == 2'd0 && HOLD) begin
              hold_state_q <= HELD;
              strobe_q     <= 4'b0000;
            end else begin
              strobe_q <= 4'b0001 << phase_q;
              phase_q  <= phase_q + 2'd1;
              case (phase_q)
                2'd0: cp1_q <= 1'b1;
                2'd1: cp1_q <= 1'b0;
                2'd2: cp2_q <= 1'b1;
                2'd3: begin
                  cp2_q <= 1'b0;
                  if (rst_cnt_q < RC_MAX) rst_cnt_q <= rst_cnt_q + 8'd1;
                  if (rst_cnt_q >= RC_LAST) resetb_q <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign CP1_POSEDGE = strobe_q[0];
  assign CP1_NEGEDGE = strobe_q[1];
  assign CP2_POSEDGE = strobe_q[2];
  assign CP2_NEGEDGE = strobe_q[3];
  assign CP1         = cp1_q;
  assign CP2         = cp2_q;
  assign RESETB      = resetb_q;
  assign HOLD_ACK    = (hold_state_q == HELD);

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Directed bench for upd7800_clkgen: one instance at CLK_DIV=1 and one at CLK_DIV=3,
// both with RESET_CYCLES=4; outputs are sampled on the falling clock edge.
module tb_upd7800_clkgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res1, hold1, res3, hold3;
  logic p1p1, p1n1, p2p1, p2n1, cp1_1, cp2_1, rb1, ack1;
  logic p1p3, p1n3, p2p3, p2n3, cp1_3, cp2_3, rb3, ack3;

  int compared   = 0;
  int mismatched = 0;

  upd7800_clkgen #(.CLK_DIV(1), .RESET_CYCLES(4)) dut1 (
    .CLK(clk), .RES(res1), .HOLD(hold1),
    .CP1_POSEDGE(p1p1), .CP1_NEGEDGE(p1n1), .CP2_POSEDGE(p2p1), .CP2_NEGEDGE(p2n1),
    .CP1(cp1_1), .CP2(cp2_1), .RESETB(rb1), .HOLD_ACK(ack1)
  );

  upd7800_clkgen #(.CLK_DIV(3), .RESET_CYCLES(4)) dut3 (
    .CLK(clk), .RES(res3), .HOLD(hold3),
    .CP1_POSEDGE(p1p3), .CP1_NEGEDGE(p1n3), .CP2_POSEDGE(p2p3), .CP2_NEGEDGE(p2n3),
    .CP1(cp1_3), .CP2(cp2_3), .RESETB(rb3), .HOLD_ACK(ack3)
  );

  // Strobes packed as {P1+, P1-, P2+, P2-}.
  function automatic logic [3:0] strb1();
    return {p1p1, p1n1, p2p1, p2n1};
  endfunction

  function automatic logic [3:0] strb3();
    return {p1p3, p1n3, p2p3, p2n3};
  endfunction

  function automatic logic [3:0] exp_strobe(input int s);
    logic [3:0] v;
    v = 4'b1000;
    return (s < 1) ? 4'b0000 : (v >> ((s - 1) % 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic [3:0] s, input logic c1, input logic c2,
                      input logic rb, input logic ack);
    chk({tag, ".strobes"}, 32'(strb1()), 32'(s));
    chk({tag, ".cp"},      32'({cp1_1, cp2_1}), 32'({c1, c2}));
    chk({tag, ".resetb"},  32'(rb1), 32'(rb));
    chk({tag, ".ack"},     32'(ack1), 32'(ack));
    $display("[%0t] %s strobes=%b cp1=%b cp2=%b resetb=%b ack=%b", $time, tag,
             strb1(), cp1_1, cp2_1, rb1, ack1);
  endtask

  // n running steps from phase 0; RESETB expected high from step rise_at on.
  task automatic run1(input string tag, input int n, input int rise_at);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk1($sformatf("%s.k%0d", tag, k), exp_strobe(k),
           ((k - 1) % 4) == 0, ((k - 1) % 4) == 2, k >= rise_at, 1'b0);
    end
  endtask

  initial begin
    res1 = 1'b1; hold1 = 1'b0; res3 = 1'b1; hold3 = 1'b0;

    // Reset held for 8 clocks
    for (int i = 0; i < 8; i++) tick();
    chk1("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release: 16 strobes, RESETB rises with the 4th CP2_NEGEDGE
    res1 = 1'b0;
    run1("boot", 16, 16);

    // HOLD raised while CP1_NEGEDGE is high: the cycle completes, then freezes
    run1("pre_hold", 2, 1);
    hold1 = 1'b1;
    tick(); chk1("hold_p2p", 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); chk1("hold_p2n", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk1($sformatf("held%0d", i), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    hold1 = 1'b0;
    tick(); chk1("release", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk1("resume_p1p", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0);

    // One-clock RES pulse mid-cycle restarts everything
    res1 = 1'b1;
    tick(); chk1("res_pulse", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    res1 = 1'b0;
    run1("restart", 8, 99);

    // HOLD for 20 clocks after two CP2_NEGEDGEs keeps RESETB low
    hold1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); chk1($sformatf("stretch_held%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    hold1 = 1'b0;
    tick(); chk1("stretch_release", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run1("stretch_tail", 8, 8);

    // RES wins over HOLD; after release the generator freezes at once
    res1 = 1'b1; hold1 = 1'b1;
    tick(); chk1("res_hold0", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk1("res_hold1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    res1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk1($sformatf("hold_after_res%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // CLK_DIV=3: strobes 3 clocks apart; a HOLD blip on a non-step edge is ignored
    chk("div3.reset", 32'({strb3(), cp1_3, cp2_3, rb3, ack3}), 32'(0));
    res3 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      int s;
      hold3 = (k == 13);
      tick();
      s = k / 3;
      chk($sformatf("div3.k%0d.strobes", k), 32'(strb3()),
          32'(((k % 3) == 0) ? exp_strobe(s) : 4'b0000));
      chk($sformatf("div3.k%0d.cp1", k), 32'(cp1_3), 32'(s >= 1 && ((s - 1) % 4) == 0));
      chk($sformatf("div3.k%0d.cp2", k), 32'(cp2_3), 32'(s >= 1 && ((s - 1) % 4) == 2));
      chk($sformatf("div3.k%0d.resetb", k), 32'(rb3), 32'(k >= 48));
      chk($sformatf("div3.k%0d.onehot0", k), 32'($onehot0(strb3())), 32'(1));
      chk($sformatf("div3.k%0d.ack", k), 32'(ack3), 32'(0));
      $display("[%0t] div3 k=%0d strobes=%b cp1=%b cp2=%b resetb=%b", $time, k,
               strb3(), cp1_3, cp2_3, rb3);
    end
    hold3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/upd7800_clkgen.md
Name: upd7800_clkgen

Overview:
- Upstream feeder for the uPD7800 core.
- Produces the four single-CLK phase strobes CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE and CP2_NEGEDGE from the master CLK, plus the CP1/CP2 level signals.
- Produces the core's active-low RESETB and keeps it low for a fixed number of machine cycles after system reset is released.
- Provides a cycle-boundary HOLD (freeze) for the console/debug logic.

Parameters:
- CLK_DIV, 1: number of CLK cycles per phase step (1..16).
- RESET_CYCLES, 4: number of complete CP1/CP2 cycles (CP2_NEGEDGE strobes) RESETB stays low after RES falls (1..255).

Ports:
- CLK  in  1  master clock; all logic on posedge.
- RES  in  1  reset; synchronous and active-high.
- HOLD  in  1  request to freeze phase generation at the next machine-cycle boundary.
- CP1_POSEDGE  out  1  one-CLK strobe, phase step 0.
- CP1_NEGEDGE  out  1  one-CLK strobe, phase step 1.
- CP2_POSEDGE  out  1  one-CLK strobe, phase step 2.
- CP2_NEGEDGE  out  1  one-CLK strobe, phase step 3.
- CP1  out  1  level; high from the CP1_POSEDGE strobe until the CP1_NEGEDGE strobe.
- CP2  out  1  level; high from the CP2_POSEDGE strobe until the CP2_NEGEDGE strobe.
- RESETB  out  1  active-low reset to the core.
- HOLD_ACK  out  1  high while the generator is frozen.

Behaviour:
- All outputs are registered.
- Reset: an edge with RES=1 sets:
  - all strobes=0, CP1=0, CP2=0, RESETB=0, HOLD_ACK=0;
  - phase=0, divider cnt=0, reset counter=0.
  - RES overrides HOLD.
- Divider:
  - While running (not RES, HOLD_ACK=0), each edge checks cnt.
  - If cnt==CLK_DIV-1: a step occurs and cnt<=0.
  - Otherwise: cnt<=cnt+1 and all strobes<=0.
- Step with phase p:
  - The strobe for p is set to 1 and the other three strobes to 0.
  - phase<=(p+1) mod 4, wrapping 3->0.
  - CP1<=1 on p=0; CP1<=0 on p=1. CP2<=1 on p=2; CP2<=0 on p=3.
- Latency: with CLK_DIV=1, CP1_POSEDGE is high in the first cycle after the first edge with RES=0. Strobes then repeat P1+, P1-, P2+, P2- with one strobe per CLK, continuously.
- General CLK_DIV: each strobe is exactly 1 CLK wide and strobes are CLK_DIV CLK cycles apart. At most one strobe is high at any time.
- Reset stretch:
  - The reset counter increments, saturating, on each step with p=3.
  - At the step that issues the RESET_CYCLES-th CP2_NEGEDGE, RESETB<=1 on the same edge the strobe is asserted.
  - RESETB then stays 1 until RES.
  - RES=1 mid-operation immediately restarts the full sequence: RESETB=0 and counters cleared on that edge.
- Hold state machine, states RUN and HELD:
  - RUN->HELD: at a step edge with phase==0 and HOLD=1. No strobe is emitted, phase stays 0, cnt<=0, HOLD_ACK<=1.
  - HOLD raised mid-cycle (phase 1..3): remaining strobes are still emitted. Freeze occurs at the next phase-0 step, so a machine cycle is never split.
  - In HELD: all strobes 0; CP1=CP2=0; cnt and the reset counter are frozen.
  - HELD->RUN: on any edge with HOLD=0, HOLD_ACK<=0 and cnt<=0. The next CP1_POSEDGE follows after CLK_DIV further edges; with CLK_DIV=1 it is asserted on the very next edge.
  - HOLD toggling at a non-step edge in RUN has no effect.
- Widths:
  - cnt is $clog2(CLK_DIV) bits, minimum 1.
  - Reset counter is 8 bits, saturating at RESET_CYCLES.
  - phase is 2 bits.

Test Plan:
- CLK_DIV=1, RESET_CYCLES=4. RES high 8 CLK, then low -> strobes P1+, P1-, P2+, P2- one per CLK starting the first cycle after release. RESETB rises on the same edge as the 4th CP2_NEGEDGE (16th strobe, CLK 16 after release).
- CLK_DIV=3 -> strobes 3 CLK apart, each 1 CLK wide. CP1 is high exactly 3 CLK per machine cycle (12 CLK). Never two strobes high together.
- HOLD=1 asserted coincident with CP1_NEGEDGE, CLK_DIV=1 -> CP2_POSEDGE and CP2_NEGEDGE are still emitted. HOLD_ACK=1 on the next edge with no CP1_POSEDGE. HOLD low -> CP1_POSEDGE on the next edge.
- HOLD held 20 CLK during the reset stretch (after 2 CP2_NEGEDGE) -> RESETB stays 0 throughout. It rises only after 2 more cycles once HOLD is released.
- RES pulsed 1 CLK mid-cycle after RESETB=1 -> all outputs return to reset values on that edge. The sequence restarts at P1+, and RESETB is low again for 4 cycles.
- RES=1 and HOLD=1 simultaneously -> HOLD_ACK=0. After RES falls with HOLD still 1, the generator freezes at the first phase-0 step: no strobes, HOLD_ACK=1, RESETB=0.
